// File: rtl/cpu_step_ctrl_pkg.sv
// Shared constants for the CPU single-step / free-run controller.
package cpu_step_ctrl_pkg;

    localparam int unsigned RUN_DIV_DEFAULT = 25_000_000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StStep = ST_STEP,
        StRun  = ST_RUN,
        StHalt = ST_HALT
    } state_t;

endpackage

// File: rtl/cpu_step_ctrl_run_prescaler.sv
// Free-run prescaler: counts 0..DIV-1 while enabled, tc flags the last count.
module run_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_100M,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tc = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step/run controller producing the processor clock enable and a pulse counter.
// Optional breakpoint halt in RUN is enabled by defining CPU_STEP_CTRL_BKPT_EN.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             step_pulse,
    input  logic             run_held,
    input  logic             clr_pulse,
    input  logic             cpu_halt,
    input  logic [3:0]       pc,
    input  logic [3:0]       bp_addr,
    input  logic             bp_en,
    output logic             cpu_ce,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] step_count,
    output logic             halted
);

    state_t           state_q;
    logic             cpu_ce_q;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;

    logic presc_clr;
    logic presc_en;
    logic presc_tc;
    logic bp_hit;

`ifdef CPU_STEP_CTRL_BKPT_EN
    assign bp_hit = bp_en && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_en};
    assign bp_hit    = 1'b0;
`endif

    // Prescaler only advances while staying in RUN; any exit or non-RUN state holds it at 0.
    assign presc_en  = (state_q == StRun);
    assign presc_clr = clr_pulse || (state_q != StRun) || cpu_halt || !run_held;

    run_prescaler #(
        .DIV (RUN_DIV)
    ) u_run_prescaler (
        .clk_100M (clk_100M),
        .rst      (rst),
        .clr      (presc_clr),
        .en       (presc_en),
        .tc       (presc_tc)
    );

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cpu_ce_q <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else if (clr_pulse) begin
            state_q  <= StIdle;
            cpu_ce_q <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cpu_ce_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cpu_halt) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (run_held) begin
                        state_q <= StRun;
                    end else if (step_pulse) begin
                        state_q  <= StStep;
                        cpu_ce_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                StStep: begin
                    state_q <= StIdle;
                end
                StRun: begin
                    if (cpu_halt) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (!run_held) begin
                        state_q <= StIdle;
                    end else if (presc_tc && bp_hit) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (presc_tc) begin
                        cpu_ce_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                StHalt: begin
                    if (!run_held && !cpu_halt) begin
                        state_q  <= StIdle;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ce     = cpu_ce_q;
    assign state_o    = state_q;
    assign step_count = cnt_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with RUN_DIV=4, CNT_W=3.
module tb_cpu_step_ctrl;

    logic       clk_100M = 1'b0;
    logic       rst;
    logic       step_pulse, run_held, clr_pulse, cpu_halt;
    logic [3:0] pc, bp_addr;
    logic       bp_en;
    logic       cpu_ce;
    logic [1:0] state_o;
    logic [2:0] step_count;
    logic       halted;

    int total = 0;
    int bad   = 0;
    int ec    = 0;

    typedef struct packed {
        logic       sp, rh, clr, hlt;
        logic       ce;
        logic [1:0] st;
        logic [2:0] cnt;
        logic       hl;
    } vec_t;

    vec_t tbl[$];

    always #5 clk_100M = ~clk_100M;

    cpu_step_ctrl #(
        .RUN_DIV (4),
        .CNT_W   (3)
    ) dut (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .step_pulse (step_pulse),
        .run_held   (run_held),
        .clr_pulse  (clr_pulse),
        .cpu_halt   (cpu_halt),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .cpu_ce     (cpu_ce),
        .state_o    (state_o),
        .step_count (step_count),
        .halted     (halted)
    );

    function automatic vec_t mk(logic sp, logic rh, logic clr, logic hlt,
                                logic ce, logic [1:0] st, logic [2:0] cnt, logic hl);
        vec_t v;
        v.sp = sp; v.rh = rh; v.clr = clr; v.hlt = hlt;
        v.ce = ce; v.st = st; v.cnt = cnt; v.hl = hl;
        return v;
    endfunction

    task automatic check(input string name, input logic ce, input logic [1:0] st,
                         input logic [2:0] cnt, input logic hl);
        total++;
        if (cpu_ce !== ce || state_o !== st || step_count !== cnt || halted !== hl) begin
            bad++;
            $display("FAIL %s: got ce=%0b st=%0d cnt=%0d hl=%0b, want ce=%0b st=%0d cnt=%0d hl=%0b",
                     name, cpu_ce, state_o, step_count, halted, ce, st, cnt, hl);
        end
    endtask

    task automatic cyc(input logic sp, input logic rh, input logic clr, input logic hlt,
                       input logic ce, input logic [1:0] st, input logic [2:0] cnt,
                       input logic hl, input string name);
        step_pulse = sp; run_held = rh; clr_pulse = clr; cpu_halt = hlt;
        @(posedge clk_100M);
        #1;
        check(name, ce, st, cnt, hl);
    endtask

    // n edges with run_held high starting from IDLE; pulse every 4th edge after entry.
    task automatic run_n(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            logic ce;
            ce = (i > 0) && (i % 4 == 0);
            if (ce) ec++;
            cyc((i == 2) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, ce, 2'd2, 3'(ec), 1'b0, name);
        end
    endtask

    initial begin
        rst = 1'b1;
        step_pulse = 0; run_held = 0; clr_pulse = 0; cpu_halt = 0;
        pc = 4'h0; bp_addr = 4'h6; bp_en = 1'b0;
        #12;
        check("reset", 1'b0, 2'd0, 3'd0, 1'b0);
        @(negedge clk_100M);
        rst = 1'b0;

        // Step table: count sequence 1..7,0,1, step ignored in STEP, then clear.
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 0));
        for (int k = 1; k <= 9; k++) begin
            tbl.push_back(mk(1, 0, 0, 0, 1, 2'd1, 3'(k % 8), 0));
            tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'(k % 8), 0));
        end
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd1, 3'd2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'd0, 3'd2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, 3'd0, 0));
        foreach (tbl[i])
            cyc(tbl[i].sp, tbl[i].rh, tbl[i].clr, tbl[i].hlt,
                tbl[i].ce, tbl[i].st, tbl[i].cnt, tbl[i].hl, $sformatf("tbl%0d", i));
        ec = 0;

        // Free run: 5 pulses, release goes to IDLE without an extra pulse.
        run_n(21, "run5");
        cyc(0, 0, 0, 0, 0, 2'd0, 3'(ec), 0, "run_release");

        // Clear coincident with an increment at count 5.
        run_n(4, "run_pre_clr");
        cyc(0, 1, 1, 0, 0, 2'd0, 3'd0, 0, "clr_on_inc");
        ec = 0;

        // Halt on the terminal cycle.
        run_n(4, "run_pre_halt");
        cyc(0, 1, 0, 1, 0, 2'd3, 3'd0, 1, "halt_on_tc");
        cyc(0, 1, 0, 0, 0, 2'd3, 3'd0, 1, "halt_hold_run");
        cyc(0, 0, 0, 1, 0, 2'd3, 3'd0, 1, "halt_hold_halt");
        cyc(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, "halt_exit");

        // IDLE priority and clear out of HALT.
        cyc(1, 1, 0, 1, 0, 2'd3, 3'd0, 1, "idle_prio_halt");
        cyc(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, "idle_back");
        cyc(1, 1, 0, 0, 0, 2'd2, 3'd0, 0, "idle_prio_run");
        cyc(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, "run_exit");
        cyc(0, 0, 0, 1, 0, 2'd3, 3'd0, 1, "halt_again");
        cyc(0, 1, 1, 1, 0, 2'd0, 3'd0, 0, "clr_in_halt");
        cyc(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, "idle_after_clr");

        // Breakpoint at the terminal cycle.
        pc = 4'h6; bp_addr = 4'h6; bp_en = 1'b1;
        run_n(4, "run_pre_bp");
`ifdef CPU_STEP_CTRL_BKPT_EN
        cyc(0, 1, 0, 0, 0, 2'd3, 3'(ec), 1, "bp_halt");
`else
        ec++;
        cyc(0, 1, 0, 0, 1, 2'd2, 3'(ec), 0, "bp_ignored");
`endif
        cyc(0, 0, 0, 0, 0, 2'd0, 3'(ec), 0, "bp_release");
        bp_en = 1'b0;

        // Asynchronous reset while cpu_ce is high.
        run_n(5, "run_pre_rst");
        rst = 1'b1;
        #1;
        check("async_rst", 1'b0, 2'd0, 3'd0, 1'b0);
        ec = 0;
        run_held = 1'b0;
        @(negedge clk_100M);
        @(negedge clk_100M);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, $sformatf("post_rst%0d", i));
        cyc(1, 0, 0, 0, 1, 2'd1, 3'd1, 0, "post_rst_step");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Back-to-back enables are never legal.
    logic ce_prev = 1'b0;
    always @(posedge clk_100M) begin
        #2;
        if (!rst && cpu_ce && ce_prev) begin
            bad++;
            $display("FAIL ce_consecutive: got ce=1 twice, want at most one cycle");
        end
        ce_prev = cpu_ce;
    end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter RUN_DIV, default 25000000, clk_100M cycles between cpu_ce pulses in RUN (4 Hz); legal range 2 and above.
REQ-002 Parameter CNT_W, default 16, width of step_count.
REQ-003 clk_100M  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 step_pulse  input  1  one-cycle pulse requesting a single instruction step (button 0).
REQ-006 run_held  input  1  debounced level; 1 requests free-run (button 1).
REQ-007 clr_pulse  input  1  one-cycle pulse: abort to IDLE and clear step_count (button 3).
REQ-008 cpu_halt  input  1  level from processor: halt instruction executed.
REQ-009 pc  input  4  processor program counter (used only with breakpoint feature).
REQ-010 bp_addr  input  4  breakpoint address (used only with breakpoint feature).
REQ-011 bp_en  input  1  breakpoint enable (used only with breakpoint feature).
REQ-012 cpu_ce  output  1  one-cycle processor clock enable, registered.
REQ-013 state_o  output  2  FSM state: IDLE=0, STEP=1, RUN=2, HALT=3.
REQ-014 step_count  output  CNT_W  number of cpu_ce pulses issued since reset/clear.
REQ-015 halted  output  1  high while state is HALT.

Function
REQ-016 FSM states IDLE, STEP, RUN, HALT; all outputs registered.
REQ-017 IDLE priority, highest first: cpu_halt -> HALT; run_held -> RUN; step_pulse -> STEP; else stay.
REQ-018 STEP lasts exactly one cycle with cpu_ce=1, then -> IDLE; step_pulse sampled at edge N gives cpu_ce high in cycle N+1.
REQ-019 RUN: prescaler cleared on entry, counts 0..RUN_DIV-1; cpu_ce=1 for the one cycle after prescaler reaches RUN_DIV-1, then prescaler wraps to 0; first pulse RUN_DIV cycles after entry.
REQ-020 RUN: run_held=0 -> IDLE next edge, prescaler cleared, no cpu_ce; step_pulse ignored.
REQ-021 RUN: cpu_halt=1 -> HALT next edge, no cpu_ce that cycle even if prescaler terminal.
REQ-022 HALT: cpu_ce=0; exits to IDLE only when run_held=0 and cpu_halt=0; step_pulse ignored.
REQ-023 clr_pulse in any state: next state IDLE, step_count=0, cpu_ce=0, prescaler=0; overrides all other inputs.
REQ-024 step_count increments by 1 on each cycle cpu_ce=1; wraps 2^CNT_W-1 -> 0 silently.
REQ-025 clr_pulse coincident with an increment: count result is 0.
REQ-026 cpu_ce never high for two consecutive cycles.

Reset
REQ-027 rst=1 forces state IDLE, cpu_ce=0, state_o=0, step_count=0, halted=0, prescaler=0, immediately and independent of clock.
REQ-028 Reset mid-RUN or mid-STEP discards any pending cpu_ce; first post-reset pulse requires a fresh step_pulse or run_held.

Configuration
REQ-029 Macro CPU_STEP_CTRL_BKPT_EN defined: in RUN, when bp_en=1 and pc==bp_addr at the prescaler terminal cycle, cpu_ce is suppressed, step_count unchanged, next state HALT; in STEP, breakpoints are not checked.
REQ-030 Macro undefined: pc, bp_addr, bp_en ports remain present but are ignored; HALT entered only via cpu_halt.

Structure
REQ-031 Shared package holds state encoding constants (ST_IDLE..ST_HALT) and the default RUN_DIV value.
REQ-032 One sub-module, run_prescaler (counter with clear, terminal-count output); FSM and step counter stay in the top.

Verification
REQ-033 RUN_DIV=4; step_pulse at cycle 10 -> cpu_ce high cycle 11 only, state_o 1 then 0, step_count=1.
REQ-034 RUN_DIV=4; run_held=1 for 20 cycles -> cpu_ce every 4th cycle, 5 pulses, step_count=5; release -> IDLE next edge, no extra pulse.
REQ-035 CNT_W=3; 9 step pulses -> step_count sequence 1..7,0,1.
REQ-036 RUN, cpu_halt=1 on terminal cycle -> no cpu_ce, state_o=3, halted=1; release run_held and cpu_halt -> state_o=0.
REQ-037 clr_pulse coincident with a cpu_ce increment at count 5 -> step_count=0, state_o=0; rst asserted mid-RUN -> all outputs 0 without clock edge.
REQ-038 With CPU_STEP_CTRL_BKPT_EN, bp_en=1, bp_addr=4'h6, pc=4'h6 at terminal -> no cpu_ce, HALT; without the macro same stimulus -> cpu_ce issued, stays RUN.
